// File: rtl/mips_pkg.sv
// Shared fetch-path constants and the instruction fetch queue FSM encoding.
// Fixed widths here; fetch address width is a parameter of the consumers.
package mips_pkg;

  localparam int          INSTR_W              = 32;
  localparam int          PC_INCR              = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP                  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer for fetched {pc, instr} entries with push/pop/flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   head_vld,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: one-outstanding memory reads into a prefetch queue feeding decode; IFQ_STATS_EN adds flush/starve counters.
// Latency: mem_req one cycle after reset release; instr_valid rises the cycle after mem_ack.
// Backpressure: instr_ready low fills the queue; issue stops once queue + outstanding reaches DEPTH.
module instr_fetch_queue
  import mips_pkg::*;
#(
  parameter int                DEPTH        = 4,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_W-1:0]     mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_W-1:0]     instr_data,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [$clog2(DEPTH):0] q_count
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]            stat_flush,
  output logic [15:0]            stat_starve
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

  ifq_state_t        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] redirect_pc;
  logic              head_vld;
  ifq_entry_t        head_dat;
  ifq_entry_t        push_dat;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  count_after;
  logic              can_chain;
  logic              can_issue;

  assign redirect_pc = redirect_addr & ~ADDR_W'(3);
  assign next_pc     = fetch_pc + ADDR_W'(PC_INCR);

  assign pop  = head_vld & instr_ready;
  // An ack that coincides with a redirect belongs to the abandoned path.
  assign push = (state == IFQ_WAIT) & mem_ack & ~redirect;

  assign push_dat.pc    = mem_addr;
  assign push_dat.instr = mem_rdata;

  assign count_after = q_count + CNT_W'(push) - CNT_W'(pop);
  assign can_chain   = ~halt & (count_after < CNT_W'(DEPTH));
  assign can_issue   = ~halt & (q_count < CNT_W'(DEPTH));

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifq_entry_t))
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (q_count)
  );

  assign instr_valid = head_vld;
  assign instr_data  = head_vld ? head_dat.instr : NOP;
  assign instr_pc    = head_vld ? head_dat.pc : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IFQ_IDLE;
      fetch_pc <= RESET_VECTOR;
      mem_req  <= 1'b0;
      mem_addr <= RESET_VECTOR;
    end else begin
      case (state)
        IFQ_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (can_issue) begin
            state    <= IFQ_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        IFQ_WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (mem_ack) begin
              state   <= IFQ_IDLE;
              mem_req <= 1'b0;
            end else begin
              // Memory still owes us this read; hold the request until it lands.
              state <= IFQ_DROP;
            end
          end else if (mem_ack) begin
            fetch_pc <= next_pc;
            if (can_chain) begin
              mem_addr <= next_pc;
            end else begin
              state   <= IFQ_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        IFQ_DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (mem_ack) begin
            state   <= IFQ_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IFQ_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFQ_STATS_EN
  logic discard;

  // Entries popped this cycle went to decode, so they are not counted as discarded.
  assign discard = redirect & (((q_count - CNT_W'(pop)) != '0) | (state == IFQ_WAIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_flush  <= '0;
      stat_starve <= '0;
    end else begin
      if (discard) stat_flush <= sat_inc16(stat_flush);
      if (instr_ready && !instr_valid) stat_starve <= sat_inc16(stat_starve);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue against a queue-based fetch model.
module tb_instr_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  q_count;
`ifdef IFQ_STATS_EN
  logic [15:0] stat_flush;
  logic [15:0] stat_starve;
`endif

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_tainted;
  logic [15:0] m_flush;
  logic [15:0] m_starve;
  int          age;
  int          lat;

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_VECTOR(RV)) dut (
    .clock         (clock),
    .reset         (reset),
    .halt          (halt),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .q_count       (q_count)
`ifdef IFQ_STATS_EN
    ,
    .stat_flush    (stat_flush),
    .stat_starve   (stat_starve)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: acks once the current request has been pending lat cycles.
  task automatic drive_mem();
    if (mem_req && age >= lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_fn(mem_addr);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pc      = RV;
    m_tainted = 1'b0;
    m_flush   = '0;
    m_starve  = '0;
    age       = 0;
  endtask

  // Advance one clock; the model predicts the edge from inputs seen at the negedge.
  task automatic tick();
    ent_t e;
    logic pop_m;
    @(negedge clock);
    pop_m = (mq.size() != 0) && instr_ready;
    if (instr_ready && mq.size() == 0 && m_starve != 16'hFFFF) m_starve++;
    if (pop_m) void'(mq.pop_front());
    if (redirect && ((mq.size() != 0) || (mem_req && !m_tainted)) && m_flush != 16'hFFFF) m_flush++;
    if (mem_req && mem_ack && !m_tainted && !redirect) begin
      e.pc   = m_pc;
      e.data = mem_fn(m_pc);
      mq.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    if (mem_req && mem_ack) m_tainted = 1'b0;
    if (redirect) begin
      mq.delete();
      m_pc = redirect_addr & ~32'h3;
      if (mem_req && !mem_ack) m_tainted = 1'b1;
    end
    if (mem_req) age = mem_ack ? 0 : age + 1;
    else age = 0;
    @(posedge clock);
    #1;
    drive_mem();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    halt = 1'b0; redirect = 1'b0; redirect_addr = '0;
    instr_ready = 1'b0; mem_ack = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    model_clear();
    drive_mem();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== RV) begin errors++; $display("FAIL reset_addr: got %h expected %h", mem_addr, RV); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_head: got %h/%h expected 0/0", instr_pc, instr_data); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", q_count); end
`ifdef IFQ_STATS_EN
    checks++; if (stat_flush !== 16'd0 || stat_starve !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_flush, stat_starve); end
`endif
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== RV) begin errors++; $display("FAIL first_req: got %b@%h expected 1@%h", mem_req, mem_addr, RV); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc = RV;
    int pops = 0;
    do_reset();
    lat = 1; instr_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr_data !== mem_fn(exp_pc)) begin
          errors++; $display("FAIL stream_head: got %h/%h expected %h/%h", instr_pc, instr_data, exp_pc, mem_fn(exp_pc));
        end
        exp_pc += 32'd4; pops++;
      end
      tick();
    end
    checks++; if (pops < 15) begin errors++; $display("FAIL stream_rate: got %0d pops expected >=15", pops); end
  endtask

  task automatic test_full();
    bit seen = 0;
    do_reset();
    lat = 0; instr_ready = 1'b0;
    repeat (20) tick();
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", q_count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b expected 0", mem_req); end
    checks++; if (mq.size() != 4) begin errors++; $display("FAIL full_pushes: got %0d expected 4", mq.size()); end
    checks++; if (instr_pc !== 32'h0 || instr_data !== mem_fn(32'h0)) begin errors++; $display("FAIL full_head: got %h/%h expected 0/%h", instr_pc, instr_data, mem_fn(32'h0)); end
    instr_ready = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (mem_req) begin
        seen = 1;
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL full_resume: got %h expected 00000010", mem_addr); end
      end else tick();
    end
    if (!seen) begin checks++; errors++; $display("FAIL full_resume_timeout: got no req expected req"); end
  endtask

  task automatic test_redirect_pending();
    bit seen = 0;
    logic [15:0] base;
    do_reset();
    lat = 1; instr_ready = 1'b1;
    for (int c = 0; c < 30 && !(mem_req && mem_addr == 32'h8 && !mem_ack); c++) tick();
    checks++; if (!(mem_req && mem_addr == 32'h8)) begin errors++; $display("FAIL rp_setup: got %b@%h expected 1@00000008", mem_req, mem_addr); end
    base = m_flush;
    lat = 3; redirect = 1'b1; redirect_addr = 32'h40;
    drive_mem();
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL rp_flush: got %b/%0d expected 0/0", instr_valid, q_count); end
`ifdef IFQ_STATS_EN
    checks++; if (stat_flush !== base + 16'd1) begin errors++; $display("FAIL rp_stat_flush: got %0d expected %0d", stat_flush, base + 16'd1); end
`endif
    for (int c = 0; c < 20 && !seen; c++) begin
      if (mem_req && !m_tainted) begin
        seen = 1;
        lat = 1;
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL rp_next_addr: got %h expected 00000040", mem_addr); end
      end else tick();
    end
    if (!seen) begin checks++; errors++; $display("FAIL rp_timeout: got no req expected req"); end
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (instr_valid) begin
        seen = 1;
        checks++; if (instr_pc !== 32'h40 || instr_data !== mem_fn(32'h40)) begin errors++; $display("FAIL rp_first_pc: got %h/%h expected 00000040/%h", instr_pc, instr_data, mem_fn(32'h40)); end
      end else tick();
    end
    if (!seen) begin checks++; errors++; $display("FAIL rp_valid_timeout: got no valid expected valid"); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    lat = 1; instr_ready = 1'b0;
    for (int c = 0; c < 30 && !(mem_req && mem_addr == 32'hC && mem_ack); c++) tick();
    checks++; if (!(mem_req && mem_addr == 32'hC && mem_ack)) begin errors++; $display("FAIL ra_setup: got %b@%h ack %b expected 1@0000000c ack 1", mem_req, mem_addr, mem_ack); end
    redirect = 1'b1; redirect_addr = 32'h103;
    tick();
    redirect = 1'b0;
    checks++; if (q_count !== 3'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: got %0d/%b expected 0/0", q_count, instr_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ra_idle: got %b expected 0", mem_req); end
`ifdef IFQ_STATS_EN
    checks++; if (stat_flush !== 16'd1) begin errors++; $display("FAIL ra_stat_flush: got %0d expected 1", stat_flush); end
`endif
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL ra_next_addr: got %b@%h expected 1@00000100", mem_req, mem_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    lat = 2; instr_ready = 1'b0;
    tick();
    halt = 1'b1;
    for (int c = 0; c < 10 && mq.size() == 0; c++) tick();
    checks++; if (q_count !== 3'd1 || instr_pc !== 32'h0) begin errors++; $display("FAIL halt_push: got %0d/%h expected 1/00000000", q_count, instr_pc); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_no_req: got %b expected 0", mem_req); end
      tick();
    end
    halt = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL halt_resume: got %b@%h expected 1@00000004", mem_req, mem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    lat = 1; instr_ready = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== RV) begin errors++; $display("FAIL areset_mem: got %b@%h expected 0@%h", mem_req, mem_addr, RV); end
    checks++; if (instr_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL areset_queue: got %b/%0d expected 0/0", instr_valid, q_count); end
    checks++; if (instr_pc !== 32'h0 || instr_data !== 32'h0) begin errors++; $display("FAIL areset_head: got %h/%h expected 0/0", instr_pc, instr_data); end
`ifdef IFQ_STATS_EN
    checks++; if (stat_flush !== 16'd0 || stat_starve !== 16'd0) begin errors++; $display("FAIL areset_stats: got %0d/%0d expected 0/0", stat_flush, stat_starve); end
`endif
    @(posedge clock);
    #3;
    reset = 1'b0;
    model_clear();
    drive_mem();
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== RV) begin errors++; $display("FAIL areset_restart: got %b@%h expected 1@%h", mem_req, mem_addr, RV); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      lat         = $urandom_range(0, 3);
      halt        = ($urandom_range(0, 9) == 0);
      instr_ready = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : ($urandom & 32'h0000_0FFF);
      drive_mem();
      checks++; if (instr_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid: got %b expected %b", instr_valid, mq.size() != 0); end
      checks++; if (int'(q_count) != mq.size()) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", q_count, mq.size()); end
      if (mq.size() != 0) begin
        checks++;
        if (instr_pc !== mq[0].pc || instr_data !== mq[0].data) begin
          errors++; $display("FAIL rnd_head: got %h/%h expected %h/%h", instr_pc, instr_data, mq[0].pc, mq[0].data);
        end
      end
      if (mem_req) begin
        checks++; if (mq.size() >= DEPTH) begin errors++; $display("FAIL rnd_space: got req with %0d queued expected <%0d", mq.size(), DEPTH); end
        if (!m_tainted) begin
          checks++; if (mem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr: got %h expected %h", mem_addr, m_pc); end
        end
      end
`ifdef IFQ_STATS_EN
      checks++; if (stat_flush !== m_flush || stat_starve !== m_starve) begin errors++; $display("FAIL rnd_stats: got %0d/%0d expected %0d/%0d", stat_flush, stat_starve, m_flush, m_starve); end
`endif
      tick();
      redirect = 1'b0;
    end
  endtask

  initial begin
    lat = 1;
    model_clear();
    test_reset();
    test_stream();
    test_full();
    test_redirect_pending();
    test_redirect_ack();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
